// File: rtl/seg7_multi_display.sv
// Multi-digit seven-segment driver.
// Converts a captured binary value to decimal (shift-add-3, one bit per
// cycle) or to hex nibbles, then drives active-low gfedcba segment codes
// with leading-zero blanking and an all-dash overflow indication.
module seg7_multi_display #(
  parameter int DIGITS = 5,
  parameter int WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  done,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int BW = 4 * DIGITS;
  localparam int PW = (WIDTH > BW) ? WIDTH : BW;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    UPDATE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [WIDTH-1:0]    shreg;
  logic [BW-1:0]       bcd;
  logic [BW-1:0]       bcd_adj;
  logic                ovf;
  logic                hex_reg;
  logic                blank_reg;
  logic [CW-1:0]       cnt;
  logic [PW-1:0]       val_pad;
  logic [7*DIGITS-1:0] seg_next;

  function automatic logic [6:0] encode(input logic [3:0] n);
    logic [6:0] code;
    case (n)
      4'h0: code = 7'b1000000;
      4'h1: code = 7'b1111001;
      4'h2: code = 7'b0100100;
      4'h3: code = 7'b0110000;
      4'h4: code = 7'b0011001;
      4'h5: code = 7'b0010010;
      4'h6: code = 7'b0000010;
      4'h7: code = 7'b1111000;
      4'h8: code = 7'b0000000;
      4'h9: code = 7'b0010000;
      4'hA: code = 7'b0001000;
      4'hB: code = 7'b0000011;
      4'hC: code = 7'b1000110;
      4'hD: code = 7'b0100001;
      4'hE: code = 7'b0000110;
      default: code = 7'b0001110;
    endcase
    return code;
  endfunction

  // Per-digit add-3 correction and display code selection.
  // A digit is blanked only when it and every digit above it are zero;
  // digit 0 always shows, so a zero value reads as a single "0".
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    localparam bit CAN_BLANK = (gi != 0);
    logic [3:0] d;
    logic       upper_nz;
    assign d        = bcd[4*gi +: 4];
    assign upper_nz = |bcd[BW-1:4*gi];
    assign bcd_adj[4*gi +: 4] = (d >= 4'd5) ? d + 4'd3 : d;
    assign seg_next[7*gi +: 7] = ovf ? SEG_DASH :
                                 (blank_reg && CAN_BLANK && !upper_nz) ? SEG_BLANK :
                                 encode(d);
  end

  // Zero-extend the captured value so hex overflow and nibble loading
  // work for any WIDTH/DIGITS combination.
  always_comb begin
    val_pad = PW'(shreg);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and busy. Hex spends a single CONV cycle staging its
  // nibbles into the digit register, giving the two-edge hex latency.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = CONV;
      end
      CONV: begin
        busy = 1'b1;
        if (hex_reg || cnt == '0) state_next = UPDATE;
      end
      UPDATE: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture, shift-add-3 / nibble load, and segment register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg     <= '0;
      bcd       <= '0;
      ovf       <= 1'b0;
      hex_reg   <= 1'b0;
      blank_reg <= 1'b0;
      cnt       <= '0;
      done      <= 1'b0;
      seg       <= '1;
    end else begin
      done <= (state == UPDATE);
      case (state)
        IDLE: begin
          if (start) begin
            shreg     <= value;
            hex_reg   <= hex_mode;
            blank_reg <= blank_lz;
            bcd       <= '0;
            ovf       <= 1'b0;
            cnt       <= CW'(WIDTH - 1);
          end
        end
        CONV: begin
          if (hex_reg) begin
            bcd <= val_pad[BW-1:0];
            ovf <= |(val_pad >> BW);
          end else begin
            // Carry out of the top digit means the value exceeds the display.
            bcd   <= {bcd_adj[BW-2:0], shreg[WIDTH-1]};
            shreg <= shreg << 1;
            ovf   <= ovf | bcd_adj[BW-1];
            if (cnt != '0) cnt <= cnt - 1'b1;
          end
        end
        UPDATE: begin
          seg <= seg_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_multi_display.sv
// Scoreboard bench for seg7_multi_display: three instances cover the
// default 5-digit/16-bit case, a 2-digit/8-bit overflow case and a
// 1-digit hex overflow case.
module tb_seg7_multi_display;

  typedef struct {
    logic [55:0] seg;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // main instance
  logic        m_start, m_hex, m_blz, m_busy, m_done;
  logic [15:0] m_value;
  logic [34:0] m_seg;
  // small instance
  logic        s_start, s_hex, s_blz, s_busy, s_done;
  logic [7:0]  s_value;
  logic [13:0] s_seg;
  // tiny instance
  logic        t_start, t_hex, t_blz, t_busy, t_done;
  logic [7:0]  t_value;
  logic [6:0]  t_seg;

  exp_t qm[$];
  exp_t qs[$];
  exp_t qt[$];

  logic [6:0] enc_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] DA = 7'b0111111;

  seg7_multi_display #(.DIGITS(5), .WIDTH(16)) u_main (
    .clk(clk), .rst(rst), .start(m_start), .value(m_value), .hex_mode(m_hex),
    .blank_lz(m_blz), .busy(m_busy), .done(m_done), .seg(m_seg));

  seg7_multi_display #(.DIGITS(2), .WIDTH(8)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .value(s_value), .hex_mode(s_hex),
    .blank_lz(s_blz), .busy(s_busy), .done(s_done), .seg(s_seg));

  seg7_multi_display #(.DIGITS(1), .WIDTH(8)) u_tiny (
    .clk(clk), .rst(rst), .start(t_start), .value(t_value), .hex_mode(t_hex),
    .blank_lz(t_blz), .busy(t_busy), .done(t_done), .seg(t_seg));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: digit extraction by division / nibble shifts.
  function automatic logic [55:0] model(input longint unsigned v, input bit hex,
                                        input bit blz, input int nd);
    logic [55:0]     r = '1;
    int              d[8];
    int              msd = 0;
    bit              ov;
    longint unsigned p = 1;
    for (int i = 0; i < nd; i++) begin
      d[i] = hex ? int'((v >> (4*i)) & 64'hF) : int'((v / p) % 10);
      p = p * 10;
    end
    ov = hex ? ((v >> (4*nd)) != 0) : (v >= p);
    for (int i = 0; i < nd; i++) if (d[i] != 0) msd = i;
    for (int i = 0; i < nd; i++)
      r[7*i +: 7] = ov ? DA : ((blz && i > msd) ? BL : enc_tab[d[i]]);
    return r;
  endfunction

  task automatic go_main(input logic [15:0] v, input bit hex, input bit blz, input logic [34:0] es);
    exp_t e;
    @(negedge clk);
    m_start = 1'b1; m_value = v; m_hex = hex; m_blz = blz;
    e.seg = {21'h1FFFFF, es};
    e.cyc = cyc + 1 + (hex ? 2 : 17);
    qm.push_back(e);
    @(negedge clk);
    m_start = 1'b0;
    m_value = 16'($urandom); m_hex = 1'($urandom); m_blz = 1'($urandom);
  endtask

  task automatic go_small(input logic [7:0] v, input bit hex, input bit blz, input logic [13:0] es);
    exp_t e;
    @(negedge clk);
    s_start = 1'b1; s_value = v; s_hex = hex; s_blz = blz;
    e.seg = {42'h3FFFFFFFFFF, es};
    e.cyc = cyc + 1 + (hex ? 2 : 9);
    qs.push_back(e);
    @(negedge clk);
    s_start = 1'b0; s_value = 8'($urandom);
  endtask

  task automatic wait_all();
    int g = 0;
    while ((qm.size() + qs.size() + qt.size()) != 0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    check_eq("drain", 64'(qm.size() + qs.size() + qt.size()), 64'd0);
    @(negedge clk);
  endtask

  // Scoreboard monitors: one line per completed transaction.
  always @(negedge clk) begin : mon_main
    exp_t e;
    if (!rst && m_done) begin
      if (qm.size() == 0) check_eq("m_spurious_done", 64'(m_done), 64'd0);
      else begin
        e = qm.pop_front();
        $display("txn main  cyc=%0d seg=%b", cyc, m_seg);
        check_eq("m_seg", 64'(m_seg), 64'(e.seg[34:0]));
        check_eq("m_latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin : mon_small
    exp_t e;
    if (!rst && s_done) begin
      if (qs.size() == 0) check_eq("s_spurious_done", 64'(s_done), 64'd0);
      else begin
        e = qs.pop_front();
        $display("txn small cyc=%0d seg=%b", cyc, s_seg);
        check_eq("s_seg", 64'(s_seg), 64'(e.seg[13:0]));
        check_eq("s_latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin : mon_tiny
    exp_t e;
    if (!rst && t_done) begin
      if (qt.size() == 0) check_eq("t_spurious_done", 64'(t_done), 64'd0);
      else begin
        e = qt.pop_front();
        $display("txn tiny  cyc=%0d seg=%b", cyc, t_seg);
        check_eq("t_seg", 64'(t_seg), 64'(e.seg[6:0]));
        check_eq("t_latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    int   nb;
    int   g;
    exp_t e;
    logic [15:0] rv;
    bit   rh, rb;

    rst = 1'b1;
    m_start = 0; m_value = 0; m_hex = 0; m_blz = 0;
    s_start = 0; s_value = 0; s_hex = 0; s_blz = 0;
    t_start = 0; t_value = 0; t_hex = 0; t_blz = 0;
    #1;
    check_eq("rst_m_seg", 64'(m_seg), 64'(35'h7FFFFFFFF));
    check_eq("rst_m_busy", 64'(m_busy), 64'd0);
    check_eq("rst_m_done", 64'(m_done), 64'd0);
    check_eq("rst_s_seg", 64'(s_seg), 64'(14'h3FFF));
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // decimal 12345 with busy/done timing
    go_main(16'd12345, 0, 0, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010});
    nb = m_busy ? 1 : 0;
    for (g = 0; g < 100; g++) begin
      @(negedge clk);
      if (m_done) break;
      if (m_busy) nb++;
    end
    check_eq("dec_done_seen", 64'(m_done), 64'd1);
    check_eq("dec_busy_cycles", 64'(nb), 64'd17);
    check_eq("dec_busy_at_done", 64'(m_busy), 64'd0);
    @(negedge clk);
    check_eq("dec_done_width", 64'(m_done), 64'd0);
    wait_all();

    // hex with leading-zero blanking
    go_main(16'hBEEF, 1, 1, {BL, 7'b0000011, 7'b0000110, 7'b0000110, 7'b0001110});
    wait_all();

    // leading zeros
    go_main(16'd7, 0, 1, {BL, BL, BL, BL, 7'b1111000});
    wait_all();
    go_main(16'd0, 0, 1, {BL, BL, BL, BL, 7'b1000000});
    wait_all();
    go_main(16'd7, 0, 0, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1111000});
    wait_all();

    // overflow on the small and tiny instances
    go_small(8'd100, 0, 0, {DA, DA});
    wait_all();
    go_small(8'd99, 0, 0, {7'b0010000, 7'b0010000});
    wait_all();
    @(negedge clk);
    t_start = 1'b1; t_value = 8'h1F; t_hex = 1'b1; t_blz = 1'b0;
    e.seg = {49'h1FFFFFFFFFFFF, DA};
    e.cyc = cyc + 3;
    qt.push_back(e);
    @(negedge clk);
    t_start = 1'b0; t_value = 8'h00;
    wait_all();

    // start while busy is ignored; value changes after capture
    go_main(16'd500, 0, 1, 35'(model(500, 0, 1, 5)));
    repeat (3) @(negedge clk);
    m_start = 1'b1; m_value = 16'd999; m_hex = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
    wait_all();
    repeat (25) @(negedge clk);

    // start in the same cycle as done is accepted
    go_main(16'd321, 0, 0, 35'(model(321, 0, 0, 5)));
    for (g = 0; g < 100 && !m_done; g++) @(negedge clk);
    m_start = 1'b1; m_value = 16'h1234; m_hex = 1'b1; m_blz = 1'b0;
    e.seg = model(16'h1234, 1, 0, 5);
    e.cyc = cyc + 3;
    qm.push_back(e);
    @(negedge clk);
    m_start = 1'b0; m_value = 16'hFFFF;
    wait_all();

    // random mix against the model
    for (int i = 0; i < 10; i++) begin
      rv = 16'($urandom_range(0, 65535));
      if (i < 3) rv = 16'($urandom_range(0, 120));
      rh = 1'($urandom);
      rb = 1'($urandom);
      go_main(rv, rh, rb, 35'(model(rv, rh, rb, 5)));
      wait_all();
    end

    // reset mid-conversion aborts both instances
    go_main(16'd54321, 0, 0, 35'(model(54321, 0, 0, 5)));
    go_small(8'd200, 0, 0, 14'(model(200, 0, 0, 2)));
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    qm.delete();
    qs.delete();
    #1;
    check_eq("mid_rst_m_seg", 64'(m_seg), 64'(35'h7FFFFFFFF));
    check_eq("mid_rst_m_busy", 64'(m_busy), 64'd0);
    check_eq("mid_rst_m_done", 64'(m_done), 64'd0);
    check_eq("mid_rst_s_seg", 64'(s_seg), 64'(14'h3FFF));
    check_eq("mid_rst_s_busy", 64'(s_busy), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("post_rst_m_seg", 64'(m_seg), 64'(35'h7FFFFFFFF));
    go_main(16'd1, 0, 1, {BL, BL, BL, BL, 7'b1111001});
    go_small(8'd42, 0, 0, {7'b0011001, 7'b0100100});
    wait_all();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
